// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-side master presenting a valid/ready stream
// A 2-entry skid buffer absorbs the FIFO's one-cycle read latency.
module fifo_stream_reader #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] rd_data,
  output logic             rd_en,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [CNT_W-1:0] word_cnt,
  output logic             idle
);

  logic [WIDTH-1:0] mem0_q, mem0_d;
  logic [WIDTH-1:0] mem1_q, mem1_d;
  logic             head_q, head_d;
  logic [1:0]       count_q, count_d;
  logic             inflight_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop;
  logic             tail;
  logic [2:0]       occ;

  always_comb begin
    pop     = (count_q != 2'd0) & m_ready;
    // Slots committed after this cycle; a same-cycle pop frees room immediately.
    occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en   = rst_n & en & ~fifo_empty & (occ < 3'd2);
    tail    = head_q ^ count_q[0];
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    if (inflight_q) begin
      if (tail) mem1_d = rd_data;
      else      mem0_d = rd_data;
    end
    head_d  = head_q ^ pop;
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
    cnt_d   = cnt_q + CNT_W'(pop);
    m_valid = (count_q != 2'd0);
    m_data  = head_q ? mem1_q : mem0_q;
    idle    = (count_q == 2'd0) & ~inflight_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q     <= '0;
      mem1_q     <= '0;
      head_q     <= 1'b0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      mem0_q     <= mem0_d;
      mem1_q     <= mem1_d;
      head_q     <= head_d;
      count_q    <= count_d;
      inflight_q <= rd_en;
      cnt_q      <= cnt_d;
    end
  end

  assign word_cnt = cnt_q;

  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, count_q} + {2'b00, inflight_q}) <= 3'd2);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader
// FIFO is modelled as an array with registered read data; a queue holds the expected word order.
module tb_fifo_stream_reader;
  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_empty;
  logic [W-1:0]  rd_data = '0;
  logic          rd_en, m_valid, idle;
  logic [W-1:0]  m_data;
  logic [CW-1:0] word_cnt;

  fifo_stream_reader #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .rd_data(rd_data),
    .rd_en(rd_en), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .word_cnt(word_cnt), .idle(idle)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_ptr[7:0]];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int delivered = 0;
  logic [W-1:0] exp_q [$];
  logic         hold_prev = 1'b0;
  logic [W-1:0] hold_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: order, no spurious words, hold-while-stalled, never read an empty FIFO.
  always @(negedge clk) begin
    if (!rst_n) begin
      delivered = 0;
      hold_prev = 1'b0;
    end else begin
      check("rd_en_while_empty", {31'd0, rd_en & fifo_empty}, 32'd0);
      if (hold_prev) begin
        check("stall_valid", {31'd0, m_valid}, 32'd1);
        check("stall_data", {16'd0, m_data}, {16'd0, hold_data});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("spurious_word", 32'd1, 32'd0);
        else check("stream_data", {16'd0, m_data}, {16'd0, exp_q.pop_front()});
        delivered++;
      end
      hold_prev = m_valid & ~m_ready;
      hold_data = m_data;
    end
  end

  task automatic load(input logic [W-1:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr++;
    exp_q.push_back(v);
  endtask

  task automatic step(input logic en_v, input logic rdy_v);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    en      = en_v;
    m_ready = rdy_v;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    en      = 1'b1;
    m_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while (!(idle && fifo_empty && exp_q.size() == 0) && n < limit) begin
      step(1'b1, 1'b1);
      n++;
    end
    check({name, "_drain_timeout"}, {31'd0, (n >= limit)}, 32'd0);
  endtask

  typedef struct {
    logic         en;
    logic         rdy;
    logic         rd_en;
    logic         vld;
    logic [W-1:0] data;
    logic         idle;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int n;
    bit done;
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 4'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 4'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd1};

    // Reset with a word waiting in the FIFO and en already high.
    rst_n = 1'b0; en = 1'b1; m_ready = 1'b1;
    load(16'h1234);
    repeat (3) @(negedge clk);
    #1;
    check("rst_rd_en", {31'd0, rd_en}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {16'd0, m_data}, 32'd0);
    check("rst_word_cnt", {28'd0, word_cnt}, 32'd0);
    check("rst_idle", {31'd0, idle}, 32'd1);

    // Single word, cycle by cycle.
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].en, tbl[i].rdy);
      check($sformatf("single_rd_en[%0d]", i), {31'd0, rd_en}, {31'd0, tbl[i].rd_en});
      check($sformatf("single_valid[%0d]", i), {31'd0, m_valid}, {31'd0, tbl[i].vld});
      if (tbl[i].vld) check($sformatf("single_data[%0d]", i), {16'd0, m_data}, {16'd0, tbl[i].data});
      check($sformatf("single_idle[%0d]", i), {31'd0, idle}, {31'd0, tbl[i].idle});
      check($sformatf("single_cnt[%0d]", i), {28'd0, word_cnt}, {28'd0, tbl[i].cnt});
    end

    // Streaming 32 words with a permanently ready sink.
    do_reset();
    for (int i = 0; i < 32; i++) load(W'(i));
    for (int c = 0; c < 40; c++) begin
      step(1'b1, 1'b1);
      check($sformatf("stream_rd_en[%0d]", c), {31'd0, rd_en}, {31'd0, (c < 32)});
      check($sformatf("stream_valid[%0d]", c), {31'd0, m_valid}, {31'd0, (c >= 2 && c < 34)});
    end
    check("stream_delivered", delivered, 32);
    check("stream_word_cnt", {28'd0, word_cnt}, 32 % 16);
    check("stream_idle", {31'd0, idle}, 32'd1);

    // Backpressure: reads stop at two, head word held, then toggling ready.
    do_reset();
    for (int i = 0; i < 8; i++) load(W'(i));
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 1'b0);
      check($sformatf("bp_rd_en[%0d]", c), {31'd0, rd_en}, {31'd0, (c < 2)});
      if (c >= 2) begin
        check($sformatf("bp_valid[%0d]", c), {31'd0, m_valid}, 32'd1);
        check($sformatf("bp_data[%0d]", c), {16'd0, m_data}, 32'd0);
      end
    end
    n = 0;
    done = 1'b0;
    while (!done && n < 60) begin
      step(1'b1, (n % 2) == 0);
      n++;
      done = idle && fifo_empty && exp_q.size() == 0;
    end
    check("bp_drain_timeout", {31'd0, done}, 32'd1);
    check("bp_delivered", delivered, 8);
    check("bp_word_cnt", {28'd0, word_cnt}, 32'd8);

    // en drops the cycle after a read: in-flight word completes, no further reads.
    do_reset();
    for (int i = 0; i < 6; i++) load(16'h0100 + W'(i));
    step(1'b1, 1'b1);
    check("endrop_first_read", {31'd0, rd_en}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b1);
      check($sformatf("endrop_rd_en[%0d]", c), {31'd0, rd_en}, 32'd0);
    end
    check("endrop_inflight_delivered", delivered, 1);
    check("endrop_fifo_nonempty", {31'd0, fifo_empty}, 32'd0);
    check("endrop_idle", {31'd0, idle}, 32'd1);
    drain("endrop", 50);
    check("endrop_delivered", delivered, 6);

    // Random en/ready with counter wrap.
    do_reset();
    for (int i = 0; i < 20; i++) load(W'($urandom));
    n = 0;
    done = 1'b0;
    while (!done && n < 2000) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      n++;
      done = idle && fifo_empty && exp_q.size() == 0;
    end
    check("rand_drain_timeout", {31'd0, done}, 32'd1);
    check("rand_delivered", delivered, 20);
    check("rand_word_cnt", {28'd0, word_cnt}, 20 % 16);
    check("rand_idle", {31'd0, idle}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
    $fatal(1);
  end

endmodule
